// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding,
// default timing parameters and the line-level decode helper.
package fifo_uart_tx_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 4;
    localparam int RD_LAT_DEFAULT       = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        WAIT  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_e;

    // Serial line level for a given state: low only for the start bit,
    // the current data bit while shifting, high (idle/stop) everywhere else.
    function automatic logic line_level(input state_e st, input logic data_bit);
        logic level;
        case (st)
            START:   level = 1'b0;
            DATA:    level = data_bit;
            default: level = 1'b1;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags the
// last cycle of each bit. The count parks at zero whenever run is low, so every
// frame starts on a fresh bit boundary.
module baud_tick_gen
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic       tick_s;

    // Next count: advance while running, reload at each bit boundary, park at zero when idle
    always_comb begin
        tick_s     = 1'b0;
        cnt_next_s = 8'd0;
        if (run) begin
            if (cnt_r == LAST_CNT) begin
                tick_s     = 1'b1;
                cnt_next_s = 8'd0;
            end else begin
                tick_s     = 1'b0;
                cnt_next_s = cnt_r + 8'd1;
            end
        end else begin
            tick_s     = 1'b0;
            cnt_next_s = 8'd0;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    // The tick must fall in the last cycle of the bit itself, so it is decoded
    // from the registered count rather than delayed by another register.
    assign tick = tick_s;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from an upstream FIFO with fixed read latency.
// One pop per frame; the popped byte is captured in the first START cycle,
// which is exactly RD_LAT cycles after the pop request. All outputs are
// registered from the next-state decode so they align with the state register.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int RD_LAT       = RD_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy
);

    // Last WAIT count; unused when RD_LAT is 1 because WAIT is skipped then.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

    state_e     state_r;
    state_e     state_next_s;
    logic [1:0] wait_cnt_r;
    logic [1:0] wait_cnt_next_s;
    logic [2:0] bit_idx_r;
    logic [2:0] bit_idx_next_s;
    logic [7:0] shift_r;
    logic [7:0] shift_next_s;
    logic       cap_pend_r;
    logic       cap_pend_next_s;
    logic       tx_r;
    logic       busy_r;
    logic       rd_en_r;
    logic       run_s;
    logic       tick_s;

    assign run_s = (state_r == START) || (state_r == DATA) || (state_r == STOP);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .run  (run_s),
        .tick (tick_s)
    );

    // Next-state, capture and shift decode
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        bit_idx_next_s  = bit_idx_r;
        shift_next_s    = shift_r;
        cap_pend_next_s = cap_pend_r;
        case (state_r)
            IDLE: begin
                // enable and fifo_empty are only ever looked at here
                if (enable && !fifo_empty) begin
                    state_next_s = POP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            POP: begin
                cap_pend_next_s = 1'b1;
                wait_cnt_next_s = 2'd0;
                if (RD_LAT == 1) begin
                    state_next_s = START;
                end else begin
                    state_next_s = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = START;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + 2'd1;
                end
            end
            START: begin
                // First START cycle is POP+RD_LAT: the FIFO data is valid now
                if (cap_pend_r) begin
                    shift_next_s    = fifo_data;
                    cap_pend_next_s = 1'b0;
                end else begin
                    cap_pend_next_s = 1'b0;
                end
                if (tick_s) begin
                    state_next_s   = DATA;
                    bit_idx_next_s = 3'd0;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    bit_idx_next_s = bit_idx_r + 3'd1;
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_next_s = STOP;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered Moore outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= 2'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            cap_pend_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            rd_en_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            bit_idx_r  <= bit_idx_next_s;
            shift_r    <= shift_next_s;
            cap_pend_r <= cap_pend_next_s;
            tx_r       <= line_level(state_next_s, shift_next_s[0]);
            busy_r     <= (state_next_s != IDLE);
            rd_en_r    <= (state_next_s == POP);
        end
    end

    assign fifo_rd_en = rd_en_r;
    assign tx         = tx_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: two instances (4 clks/bit with read
// latency 2, and 2 clks/bit with read latency 1), behavioural FIFO models with
// the matching read latency, and a scoreboard of expected serial frames.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // expected line bits, index 0 = start bit
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       enable0 = 1'b0;
    logic       fifo_empty0 = 1'b1;
    logic [7:0] fifo_data0;
    logic       rd_en0, tx0, busy0;
    logic       enable1 = 1'b0;
    logic       fifo_empty1 = 1'b1;
    logic [7:0] fifo_data1;
    logic       rd_en1, tx1, busy1;

    int n_cmp = 0;
    int n_err = 0;
    int frames0 = 0;

    logic [7:0] fifo_q0[$];
    logic [7:0] fifo_q1[$];
    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    int         pops0 = 0;
    int         pops1 = 0;
    logic       underflow0 = 1'b0;
    logic       underflow1 = 1'b0;
    logic [7:0] last0 = 8'h00;
    logic [7:0] last1 = 8'h00;
    logic [7:0] pipe0_a = 8'h00;
    logic [7:0] pipe0_b = 8'h00;
    logic [7:0] pipe1_a = 8'h00;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .RD_LAT(2)) dut0 (
        .clk(clk), .reset(reset), .enable(enable0), .fifo_empty(fifo_empty0),
        .fifo_data(fifo_data0), .fifo_rd_en(rd_en0), .tx(tx0), .busy(busy0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(2), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable1), .fifo_empty(fifo_empty1),
        .fifo_data(fifo_data1), .fifo_rd_en(rd_en1), .tx(tx1), .busy(busy1)
    );

    // Data is valid only RD_LAT cycles after the pop; other cycles carry the
    // inverse of the last popped byte so an early/late capture is visible.
    assign fifo_data0 = pipe0_b;
    assign fifo_data1 = pipe1_a;

    // Upstream FIFO model for dut0 (read latency 2)
    always @(posedge clk) begin
        if (rd_en0 && fifo_q0.size() != 0) begin
            pipe0_a <= fifo_q0[0];
            last0   <= fifo_q0[0];
            void'(fifo_q0.pop_front());
            pops0   <= pops0 + 1;
        end else begin
            pipe0_a <= ~last0;
            if (rd_en0) underflow0 <= 1'b1;
        end
        pipe0_b     <= pipe0_a;
        fifo_empty0 <= (fifo_q0.size() == 0);
    end

    // Upstream FIFO model for dut1 (read latency 1)
    always @(posedge clk) begin
        if (rd_en1 && fifo_q1.size() != 0) begin
            pipe1_a <= fifo_q1[0];
            last1   <= fifo_q1[0];
            void'(fifo_q1.pop_front());
            pops1   <= pops1 + 1;
        end else begin
            pipe1_a <= ~last1;
            if (rd_en1) underflow1 <= 1'b1;
        end
        fifo_empty1 <= (fifo_q1.size() == 0);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Follows one dut0 frame from the pop to the IDLE cycle after STOP.
    // drop_at / rst_at: frame bit index (1 = DATA bit 0) at which enable is
    // dropped or reset is asserted; -1 disables.
    task automatic check_frame0(input int drop_at, input int rst_at);
        logic [9:0] exp_frame;
        int k;
        k = 0;
        while (!rd_en0 && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk1("pop_seen", rd_en0, 1'b1);
        if (!rd_en0) return;
        frames0++;
        chki("scoreboard_ready", exp_q0.size() > 0 ? 1 : 0, 1);
        if (exp_q0.size() == 0) return;
        exp_frame = exp_q0.pop_front();
        chk1("pop_busy", busy0, 1'b1);
        chk1("pop_tx", tx0, 1'b1);
        @(negedge clk);
        chk1("wait_rd_en", rd_en0, 1'b0);
        chk1("wait_tx", tx0, 1'b1);
        chk1("wait_busy", busy0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                chk1($sformatf("frame_bit%0d_cyc%0d_tx", i, j), tx0, exp_frame[i]);
                chk1("frame_busy", busy0, 1'b1);
                chk1("frame_rd_en", rd_en0, 1'b0);
                if (i == drop_at && j == 1) enable0 = 1'b0;
                if (i == rst_at && j == 1) begin
                    reset = 1'b1;
                    @(negedge clk);
                    chk1("rst_tx", tx0, 1'b1);
                    chk1("rst_busy", busy0, 1'b0);
                    chk1("rst_rd_en", rd_en0, 1'b0);
                    return;
                end
            end
        end
        @(negedge clk);
        chk1("gap_busy", busy0, 1'b0);
        chk1("gap_tx", tx0, 1'b1);
        chk1("gap_rd_en", rd_en0, 1'b0);
    endtask

    // Time limit so the bench always ends
    initial begin
        #500000;
        $display("FAIL watchdog: bench still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[4];
        int   p_before;
        logic [9:0] f1;
        int   k;

        tbl[0] = '{8'hA5, {1'b1, 8'hA5, 1'b0}};
        tbl[1] = '{8'h01, {1'b1, 8'h01, 1'b0}};
        tbl[2] = '{8'hC3, {1'b1, 8'hC3, 1'b0}};
        tbl[3] = '{8'h7E, {1'b1, 8'h7E, 1'b0}};

        // Reset state
        repeat (3) @(negedge clk);
        chk1("reset_tx0", tx0, 1'b1);
        chk1("reset_busy0", busy0, 1'b0);
        chk1("reset_rd_en0", rd_en0, 1'b0);
        chk1("reset_tx1", tx1, 1'b1);
        chk1("reset_busy1", busy1, 1'b0);
        chk1("reset_rd_en1", rd_en1, 1'b0);
        reset   = 1'b0;
        enable0 = 1'b1;

        // Table-driven single frames
        for (int t = 0; t < 4; t++) begin
            fifo_q0.push_back(tbl[t].data);
            exp_q0.push_back(tbl[t].frame);
            check_frame0(-1, -1);
        end

        // Back-to-back 0x00, 0xFF: two pops, one IDLE cycle between, no extra pop
        p_before = pops0;
        fifo_q0.push_back(8'h00);
        exp_q0.push_back({1'b1, 8'h00, 1'b0});
        fifo_q0.push_back(8'hFF);
        exp_q0.push_back({1'b1, 8'hFF, 1'b0});
        check_frame0(-1, -1);
        check_frame0(-1, -1);
        repeat (20) begin
            @(negedge clk);
            chk1("b2b_no_extra_pop", rd_en0, 1'b0);
        end
        chki("b2b_pop_count", pops0 - p_before, 2);

        // Empty FIFO with enable high: nothing happens
        repeat (100) begin
            @(negedge clk);
            chk1("empty_rd_en", rd_en0, 1'b0);
            chk1("empty_tx", tx0, 1'b1);
            chk1("empty_busy", busy0, 1'b0);
        end

        // Enable dropped in DATA bit 3 of 0x3C: frame completes, no new pop while low
        p_before = pops0;
        fifo_q0.push_back(8'h3C);
        exp_q0.push_back({1'b1, 8'h3C, 1'b0});
        fifo_q0.push_back(8'h96);
        exp_q0.push_back({1'b1, 8'h96, 1'b0});
        check_frame0(4, -1);
        repeat (20) begin
            @(negedge clk);
            chk1("drop_no_pop", rd_en0, 1'b0);
            chk1("drop_idle_busy", busy0, 1'b0);
        end
        chki("drop_pop_count", pops0 - p_before, 1);
        enable0 = 1'b1;
        check_frame0(-1, -1);

        // Reset in DATA bit 5: immediate idle, then a clean frame after release
        fifo_q0.push_back(8'h6B);
        exp_q0.push_back({1'b1, 8'h6B, 1'b0});
        check_frame0(-1, 6);
        p_before = pops0;
        fifo_q0.push_back(8'h2D);
        exp_q0.push_back({1'b1, 8'h2D, 1'b0});
        @(negedge clk);
        chk1("rst_hold_rd_en", rd_en0, 1'b0);
        chk1("rst_hold_tx", tx0, 1'b1);
        reset = 1'b0;
        check_frame0(-1, -1);
        chki("rst_fresh_pop_count", pops0 - p_before, 1);

        // dut1: read latency 1, 2 clks/bit, byte 0x81, 20-cycle frame
        fifo_q1.push_back(8'h81);
        exp_q1.push_back({1'b1, 8'h81, 1'b0});
        enable1 = 1'b1;
        k = 0;
        while (!rd_en1 && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk1("lat1_pop_seen", rd_en1, 1'b1);
        f1 = exp_q1.pop_front();
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                chk1($sformatf("lat1_bit%0d_cyc%0d_tx", i, j), tx1, f1[i]);
                chk1("lat1_busy", busy1, 1'b1);
                chk1("lat1_rd_en", rd_en1, 1'b0);
            end
        end
        @(negedge clk);
        chk1("lat1_end_busy", busy1, 1'b0);
        chk1("lat1_end_tx", tx1, 1'b1);
        chki("lat1_pop_count", pops1, 1);

        // One pop per frame and no pop from an empty FIFO
        chki("total_pops0", pops0, frames0);
        chk1("underflow0", underflow0, 1'b0);
        chk1("underflow1", underflow1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
